// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC generator with branch redirect, stall hold,
// exception entry/return and a short invalid-fetch flush window.
module pc_sequencer #(
  parameter int unsigned           XLEN         = 32,
  parameter logic [XLEN-1:0]       RESET_PC     = 1000,
  parameter int unsigned           INC          = 4,
  parameter int unsigned           ALIGN_BITS   = 2,
  parameter logic [XLEN-1:0]       EXC_VECTOR   = 32'h0000_2000,
  parameter int unsigned           FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_req,
  input  logic            exc_return,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_err
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] INC_V      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [3:0]      FLUSH_CNT  = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;

  // Entering the handler or returning from it only opens a flush window
  // when one is configured; with zero flush cycles we stay in RUN.
  localparam state_t REDIRECT_STATE = (FLUSH_CNT != 4'd0) ? FLUSH : RUN;

  // State, PC, EPC, flush counter and misalign pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state and next-PC selection with fixed request priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (exc_req) begin
          epc_d   = pc_q;
          pc_d    = EXC_VECTOR;
          cnt_d   = FLUSH_CNT;
          state_d = REDIRECT_STATE;
        end else if (exc_return) begin
          pc_d    = epc_q;
          cnt_d   = FLUSH_CNT;
          state_d = REDIRECT_STATE;
        end else if (br_taken) begin
          pc_d  = br_target & ~ALIGN_MASK;
          mis_d = |(br_target & ALIGN_MASK);
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_q + INC_V;
        end
      end
      FLUSH: begin
        // Only a fresh exception is honoured here; it restarts the window
        // without overwriting the EPC saved on first entry.
        if (exc_req) begin
          pc_d  = EXC_VECTOR;
          cnt_d = FLUSH_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output drive; next_pc is purely combinational from the current PC.
  always_comb begin
    pc           = pc_q;
    next_pc      = pc_q + INC_V;
    pc_valid     = (state_q == RUN);
    epc          = epc_q;
    misalign_err = mis_q;
  end

endmodule
